// File: rtl/fir_mac_sched.sv
// fir_mac_sched: time-multiplexed FIR filter sharing one signed MAC engine
// between CHANNELS sample streams. Samples are arbitrated round-robin, each
// channel owns a TAPS-deep circular delay region, and every accepted sample
// is convolved through a 3-stage multiply-accumulate pipeline.
// Optional build macro: FIR_SAT_EN (saturate the shifted accumulator to
// WIDTH bits instead of wrapping on overflow).
module fir_mac_sched #(
    parameter int WIDTH    = 24,
    parameter int TAPS     = 128,
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 48,
    parameter int SHIFT    = 18
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [CHANNELS-1:0]                          in_valid,
    output logic [CHANNELS-1:0]                          in_ready,
    input  logic [CHANNELS*WIDTH-1:0]                    in_data,
    output logic [$clog2(TAPS)-1:0]                      coef_addr,
    input  logic signed [WIDTH-1:0]                      coef_data,
    output logic                                         busy,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic signed [WIDTH-1:0]                      out_data,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan
);

    localparam int AW = $clog2(TAPS);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = AW + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RUN,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]           rr_ptr;
    logic [CW-1:0]           cur_chan;
    logic [CW-1:0]           grant_idx;
    logic                    grant_found;
    logic signed [WIDTH-1:0] sample_q;
    logic [AW-1:0]           wptr [CHANNELS];
    logic [FW-1:0]           fill [CHANNELS];
    logic [AW-1:0]           tap_k;
    logic [1:0]              drain_cnt;

    // Delay memory: one TAPS-deep region per channel, addressed {chan, index}.
    logic signed [WIDTH-1:0] dline [(1 << CW) * TAPS];
    logic [AW-1:0]           rd_idx;
    logic signed [WIDTH-1:0] rd_q;
    logic                    rd_ok;
    logic                    rd_vld;

    // MAC pipeline registers
    logic signed [WIDTH-1:0] s1_coef;
    logic signed [WIDTH-1:0] s1_x;
    logic                    s1_vld;
    logic signed [PW-1:0]    s2_prod;
    logic                    s2_vld;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH-1:0] result;

    assign busy      = (state != S_IDLE);
    assign coef_addr = (state == S_RUN) ? tap_k : '0;
    assign rd_idx    = wptr[cur_chan] - AW'(1) - tap_k;
    assign prod_ext  = ACC_W'(s2_prod);

    // Pick the first requesting channel at or after the round-robin pointer;
    // scanning downwards lets the smallest offset win the final assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[(int'(rr_ptr) + i) % CHANNELS]) begin
                grant_found = 1'b1;
                grant_idx   = CW'((int'(rr_ptr) + i) % CHANNELS);
            end
        end
    end

    // Only the granted channel sees ready, and only while idle.
    always_comb begin
        in_ready = '0;
        if (state == S_IDLE && grant_found) begin
            in_ready = CHANNELS'(1) << grant_idx;
        end
    end

    // Next-state logic for the IDLE/WRITE/RUN/DRAIN/OUT sequence.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (grant_found) next_state = S_WRITE;
            S_WRITE: next_state = S_RUN;
            S_RUN:   if (tap_k == AW'(TAPS - 1)) next_state = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'd2) next_state = S_OUT;
            S_OUT:   if (out_valid && out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Control state: FSM, arbitration pointer, per-channel pointers and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            cur_chan  <= '0;
            sample_q  <= '0;
            tap_k     <= '0;
            drain_cnt <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                wptr[c] <= '0;
                fill[c] <= '0;
            end
        end else begin
            state     <= next_state;
            tap_k     <= (state == S_RUN) ? tap_k + AW'(1) : '0;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (state == S_IDLE && grant_found) begin
                cur_chan <= grant_idx;
                sample_q <= in_data[grant_idx * WIDTH +: WIDTH];
                rr_ptr   <= (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
            end
            if (state == S_WRITE) begin
                wptr[cur_chan] <= wptr[cur_chan] + AW'(1);
                if (fill[cur_chan] != FW'(TAPS)) begin
                    fill[cur_chan] <= fill[cur_chan] + FW'(1);
                end
            end
        end
    end

    // Delay memory write and synchronous read; never cleared, stale history
    // is hidden by the fill-count mask instead.
    always_ff @(posedge clk) begin
        if (state == S_WRITE) begin
            dline[{cur_chan, wptr[cur_chan]}] <= sample_q;
        end
        rd_q <= dline[{cur_chan, rd_idx}];
    end

    // Three-stage MAC: align operands, multiply, accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok   <= 1'b0;
            rd_vld  <= 1'b0;
            s1_coef <= '0;
            s1_x    <= '0;
            s1_vld  <= 1'b0;
            s2_prod <= '0;
            s2_vld  <= 1'b0;
            acc     <= '0;
        end else begin
            rd_ok   <= ({1'b0, tap_k} < fill[cur_chan]);
            rd_vld  <= (state == S_RUN);
            s1_coef <= coef_data;
            s1_x    <= rd_ok ? rd_q : '0;
            s1_vld  <= rd_vld;
            s2_prod <= s1_coef * s1_x;
            s2_vld  <= s1_vld;
            if (state == S_WRITE) begin
                acc <= '0;
            end else if (s2_vld) begin
                acc <= acc + prod_ext;
            end
        end
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0] acc_shift;
    assign acc_shift = acc >>> SHIFT;

    // Clamp the scaled accumulator into the signed output range.
    always_comb begin
        result = WIDTH'(acc_shift);
        if (acc_shift > SAT_MAX) begin
            result = WIDTH'(SAT_MAX);
        end else if (acc_shift < SAT_MIN) begin
            result = WIDTH'(SAT_MIN);
        end
    end
`else
    // Keep the low WIDTH bits of the scaled accumulator; overflow wraps.
    always_comb begin
        result = WIDTH'(acc >>> SHIFT);
    end
`endif

    // Result register: loaded once on entering OUT, held under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (state == S_OUT && !out_valid) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_chan  <= cur_chan;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
